wrapper_dmac_resp: RTL and testbench

WRAPPER_DMAC_RESP -- requirements
Module: wrapper_dmac_resp

---
 rtl/wrapper_dmac_resp.sv | 119 +++++++++++
 tb/tb_wrapper_dmac_resp.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wrapper_dmac_resp.sv
// Round-robin DMA request arbiter and burst sequencer: grants one eligible
// channel at a time and paces its beats to the bus engine.

module dmac_chan_lane #(
    parameter int IDX = 0
) (
    input  logic [2:0] grant,
    input  logic       in_xfer,
    input  logic       in_done,
    output logic       active,
    output logic       done
);
    logic sel;

    assign sel    = (grant == 3'(IDX));
    assign active = sel & in_xfer;
    assign done   = sel & in_done;
endmodule

module wrapper_dmac_resp #(
    parameter int NCHAN = 5,
    parameter int BEATW = 10
) (
    input  logic             hclk,
    input  logic             hreset,
    input  logic [NCHAN-1:0] dma_req,
    input  logic [NCHAN-1:0] chan_en,
    input  logic [BEATW-1:0] burst_len,
    output logic [NCHAN-1:0] dma_active,
    output logic [NCHAN-1:0] dma_done,
    output logic             xfer_valid,
    output logic [2:0]       xfer_chan,
    input  logic             xfer_ready,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    localparam logic [BEATW-1:0] ONE = BEATW'(1);

    state_t           state, state_nxt;
    logic [2:0]       rr_ptr;
    logic [2:0]       grant;
    logic [BEATW-1:0] len_q;
    logic [BEATW-1:0] beat_cnt;

    logic [NCHAN-1:0] eligible;
    logic             arb_found;
    logic [2:0]       arb_idx;
    logic             beat_acc;
    logic             last_beat;
    logic             in_xfer;
    logic             in_done;

    assign eligible = dma_req & chan_en;

    // Scan from rr_ptr upward with wrap; the first eligible channel wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = 3'd0;
        for (int i = 0; i < NCHAN; i++) begin
            if (!arb_found && eligible[(int'(rr_ptr) + i) % NCHAN]) begin
                arb_found = 1'b1;
                arb_idx   = 3'((int'(rr_ptr) + i) % NCHAN);
            end
        end
    end

    assign beat_acc  = (state == XFER) & xfer_ready;
    // len_q is never 0, so len_q-1 cannot underflow and beat_cnt never wraps.
    assign last_beat = beat_acc & (beat_cnt == (len_q - ONE));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (arb_found) state_nxt = XFER;
            XFER:    if (last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state    <= IDLE;
            rr_ptr   <= 3'd0;
            grant    <= 3'd0;
            len_q    <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && arb_found) begin
                grant    <= arb_idx;
                len_q    <= (burst_len == '0) ? ONE : burst_len;
                beat_cnt <= '0;
            end else if (beat_acc && !last_beat) begin
                beat_cnt <= beat_cnt + ONE;
            end
            if (state == DONE)
                rr_ptr <= (grant == 3'(NCHAN - 1)) ? 3'd0 : grant + 3'd1;
        end
    end

    // Outputs are forced low while hreset is high, not only after the edge.
    assign in_xfer    = (state == XFER) & ~hreset;
    assign in_done    = (state == DONE) & ~hreset;
    assign xfer_valid = in_xfer;
    assign xfer_chan  = in_xfer ? grant : 3'd0;
    assign busy       = (state != IDLE) & ~hreset;

    for (genvar g = 0; g < NCHAN; g++) begin : g_lane
        dmac_chan_lane #(.IDX(g)) u_lane (
            .grant   (grant),
            .in_xfer (in_xfer),
            .in_done (in_done),
            .active  (dma_active[g]),
            .done    (dma_done[g])
        );
    end
endmodule

// File: tb/tb_wrapper_dmac_resp.sv
// Bench for wrapper_dmac_resp: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_wrapper_dmac_resp;
    localparam int NCHAN = 5;
    localparam int BEATW = 10;

    logic       hclk = 1'b0;
    logic       hreset = 1'b1;
    logic [4:0] dma_req = '0;
    logic [4:0] chan_en = '0;
    logic [9:0] burst_len = '0;
    logic       xfer_ready = 1'b0;
    logic [4:0] dma_active, dma_done;
    logic       xfer_valid;
    logic [2:0] xfer_chan;
    logic       busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 hclk = ~hclk;

    wrapper_dmac_resp #(.NCHAN(NCHAN), .BEATW(BEATW)) dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .dma_req    (dma_req),
        .chan_en    (chan_en),
        .burst_len  (burst_len),
        .dma_active (dma_active),
        .dma_done   (dma_done),
        .xfer_valid (xfer_valid),
        .xfer_chan  (xfer_chan),
        .xfer_ready (xfer_ready),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a burst is just "beats remaining" on a channel, followed by a
    // one-cycle completion; the next search starts after the finished channel.
    int m_rem = 0, m_chan = 0, m_next = 0, m_done_chan = 0;
    bit m_done = 1'b0;

    always @(posedge hclk) begin
        if (hreset) begin
            m_rem  = 0;
            m_done = 1'b0;
            m_next = 0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_next = (m_done_chan + 1) % NCHAN;
        end else if (m_rem > 0) begin
            if (xfer_ready) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done      = 1'b1;
                    m_done_chan = m_chan;
                end
            end
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                int c;
                c = (m_next + i) % NCHAN;
                if (dma_req[c] && chan_en[c]) begin
                    m_chan = c;
                    m_rem  = (burst_len == 0) ? 1 : int'(burst_len);
                    break;
                end
            end
        end
    end

    bit         chk_en = 1'b0;
    bit         seen_act0 = 1'b0;
    logic [4:0] done_log[$];

    always @(negedge hclk) begin
        logic       e_v, e_busy;
        logic [4:0] e_act, e_done;
        if (chk_en) begin
            e_v    = !hreset && (m_rem > 0);
            e_act  = e_v ? 5'(1 << m_chan) : 5'd0;
            e_done = (!hreset && m_done) ? 5'(1 << m_done_chan) : 5'd0;
            e_busy = !hreset && (m_rem > 0 || m_done);
            chk("active", 32'(dma_active), 32'(e_act));
            chk("done", 32'(dma_done), 32'(e_done));
            chk("valid", 32'(xfer_valid), 32'(e_v));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("overlap", 32'(dma_active & dma_done), 32'd0);
            if (e_v) chk("chan", 32'(xfer_chan), 32'(m_chan));
            if (dma_done != 5'd0) done_log.push_back(dma_done);
            if (dma_active[0]) seen_act0 = 1'b1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge hclk);
            #1;
        end
    endtask

    task automatic do_reset;
        hreset  = 1'b1;
        dma_req = '0;
        cyc(2);
        hreset = 1'b0;
    endtask

    task automatic wait_idle;
        int k;
        k = 0;
        while (busy && k < 3000) begin
            cyc(1);
            k++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [5:0] vb;
        logic [4:0] db[6];
        logic [2:0] cb[6];
        logic [5:0] bb;
        logic [7:0] pat;
        logic [4:0] dval;
        logic [4:0] rr_exp[6];
        int acc, dk, vcnt;

        cyc(1);
        chk_en = 1'b1;
        cyc(2);
        chk("rst_active", 32'(dma_active), 32'd0);
        chk("rst_done", 32'(dma_done), 32'd0);
        chk("rst_valid", 32'(xfer_valid), 32'd0);
        chk("rst_chan", 32'(xfer_chan), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        hreset = 1'b0;
        cyc(1);

        // Single request on channel 2, 4 beats.
        chan_en = 5'h1F; dma_req = 5'h04; burst_len = 10'd4; xfer_ready = 1'b1;
        cyc(1);
        dma_req = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge hclk);
            vb[k] = xfer_valid; db[k] = dma_done; cb[k] = xfer_chan; bb[k] = busy;
        end
        cyc(1);
        chk("s1_valid_pat", 32'(vb), 32'h0F);
        chk("s1_chan0", 32'(cb[0]), 32'd2);
        chk("s1_chan3", 32'(cb[3]), 32'd2);
        chk("s1_done3", 32'(db[3]), 32'd0);
        chk("s1_done4", 32'(db[4]), 32'h04);
        chk("s1_busy_after", 32'(bb[5]), 32'd0);

        // Backpressure, 3 beats on channel 0.
        dma_req = 5'h01; burst_len = 10'd3; xfer_ready = 1'b1;
        cyc(1);
        dma_req = '0;
        pat = 8'b1111_0101;
        acc = 0; dk = -1; dval = '0;
        for (int k = 0; k < 8; k++) begin
            xfer_ready = pat[k];
            @(negedge hclk);
            if (xfer_valid && xfer_ready) acc++;
            if (dma_done != 5'd0 && dk < 0) begin
                dk = k;
                dval = dma_done;
            end
            cyc(1);
        end
        chk("s2_accepts", 32'(acc), 32'd3);
        chk("s2_done_cycle", 32'(dk), 32'd5);
        chk("s2_done_val", 32'(dval), 32'h01);

        // Round robin over all channels from a fresh reset.
        do_reset;
        cyc(1);
        done_log.delete();
        dma_req = 5'h1F; burst_len = 10'd1; xfer_ready = 1'b1;
        cyc(20);
        dma_req = '0;
        wait_idle;
        rr_exp = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h01};
        chk("s3_count_ok", 32'(done_log.size() >= 6), 32'd1);
        if (done_log.size() >= 6)
            for (int i = 0; i < 6; i++) chk("s3_rr_order", 32'(done_log[i]), 32'(rr_exp[i]));

        // Enable gating.
        done_log.delete();
        seen_act0 = 1'b0;
        dma_req = 5'h03; chan_en = 5'h02; burst_len = 10'd2;
        cyc(15);
        dma_req = '0;
        wait_idle;
        chk("s4_ch0_never", 32'(seen_act0), 32'd0);
        chk("s4_serviced", 32'(done_log.size() > 0), 32'd1);
        foreach (done_log[i]) chk("s4_done_ch1", 32'(done_log[i]), 32'h02);
        chan_en = 5'h1F;

        // Reset in the middle of an 8-beat burst.
        done_log.delete();
        dma_req = 5'h01; burst_len = 10'd8; xfer_ready = 1'b1;
        cyc(1);
        dma_req = '0;
        cyc(3);
        hreset = 1'b1;
        @(negedge hclk);
        chk("s5_rst_valid", 32'(xfer_valid), 32'd0);
        chk("s5_rst_active", 32'(dma_active), 32'd0);
        cyc(1);
        hreset = 1'b0;
        @(negedge hclk);
        chk("s5_post_valid", 32'(xfer_valid), 32'd0);
        chk("s5_post_done", 32'(dma_done), 32'd0);
        chk("s5_post_busy", 32'(busy), 32'd0);
        chk("s5_no_done", 32'(done_log.size()), 32'd0);
        cyc(1);
        dma_req = 5'h11; burst_len = 10'd2;
        cyc(1);
        @(negedge hclk);
        chk("s5_regrant_ch0", 32'(dma_active), 32'h01);
        cyc(1);
        dma_req = '0;
        wait_idle;

        // burst_len of 0 yields one beat.
        dma_req = 5'h08; burst_len = 10'd0;
        cyc(1);
        dma_req = '0;
        vcnt = 0; dval = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge hclk);
            if (xfer_valid) vcnt++;
            if (dma_done != 5'd0) dval = dma_done;
        end
        cyc(1);
        chk("s6_one_beat", 32'(vcnt), 32'd1);
        chk("s6_done", 32'(dval), 32'h08);

        // Maximum length; burst_len changes mid-burst must not matter.
        dma_req = 5'h01; burst_len = 10'h3FF;
        cyc(1);
        dma_req = '0;
        vcnt = 0; dval = '0;
        for (int k = 0; k < 1100; k++) begin
            @(negedge hclk);
            if (xfer_valid) vcnt++;
            if (dma_done != 5'd0) begin
                dval = dma_done;
                break;
            end
            cyc(1);
            if (k == 10) burst_len = 10'd5;
        end
        cyc(1);
        chk("s7_max_beats", 32'(vcnt), 32'd1023);
        chk("s7_done", 32'(dval), 32'h01);

        // Random traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            hreset     = ($urandom_range(0, 199) == 0);
            dma_req    = 5'($urandom);
            chan_en    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h1F;
            burst_len  = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 40))
                                                     : 10'($urandom_range(0, 4));
            xfer_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        hreset = 1'b0;
        dma_req = '0;
        xfer_ready = 1'b1;
        wait_idle;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
